// File: rtl/job_writer_pkg.sv
// Shared constants and state encoding for the job result writer.
package job_writer_pkg;

  localparam logic [2:0]  AWSIZE_128B    = 3'd7;
  localparam logic [1:0]  BURST_INCR     = 2'd1;
  localparam logic [3:0]  CACHE_NORMAL   = 4'd3;
  localparam int unsigned BEAT_BYTES     = 128;
  localparam int unsigned RES_FIFO_DEPTH = 32;
  localparam int unsigned RES_CNT_W      = $clog2(RES_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StAw      = 2'd2,
    StW       = 2'd3
  } state_e;

endpackage

// File: rtl/job_writer_result_fifo.sv
// First-word-fall-through result buffer: the head entry is driven on rdata_o whenever
// count_o is non-zero. DEPTH must be a power of two so the pointers wrap naturally.
module result_fifo
  import job_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1024,
  parameter int unsigned DEPTH      = RES_FIFO_DEPTH,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (count_q != '0);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/job_writer.sv
// Job result writer: buffers result beats and streams them to memory as AXI INCR bursts
// that never cross a 4 KB page, limiting how many bursts may await a write response.
module job_writer
  import job_writer_pkg::*;
#(
  parameter int unsigned ID_WIDTH        = 1,
  parameter int unsigned AWUSER_WIDTH    = 9,
  parameter int unsigned DATA_WIDTH      = 1024,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned BURST_BEATS     = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_start_i,
  input  logic [ADDR_WIDTH-1:0]   job_addr_i,
  input  logic [AWUSER_WIDTH-1:0] job_user_i,
  input  logic                    job_done_i,
  input  logic                    res_valid_i,
  output logic                    res_ready_o,
  input  logic [DATA_WIDTH-1:0]   res_data_i,
  output logic                    done_o,
  output logic                    error_o,
  output logic                    idle_o,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic [AWUSER_WIDTH-1:0] m_axi_awuser,
  output logic [3:0]              m_axi_awcache,
  output logic [1:0]              m_axi_awlock,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic [3:0]              m_axi_awregion,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int unsigned OutW     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [5:0]  BurstMax = 6'(BURST_BEATS);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [AWUSER_WIDTH-1:0] user_q, user_d;
  logic                    done_pend_q, done_pend_d;
  logic                    error_q, error_d;
  logic [5:0]              beats_q, beats_d;
  logic [5:0]              beat_idx_q, beat_idx_d;
  logic [OutW-1:0]         out_q, out_d;

  logic [RES_CNT_W-1:0]    fifo_count;
  logic                    fifo_full;
  logic [5:0]              page_room, beats_calc;
  logic                    push, aw_hs, w_hs, b_ok, can_issue, fill_ok, job_end;

  result_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RES_FIFO_DEPTH),
    .CNT_W      (RES_CNT_W)
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (res_data_i),
    .pop_i   (w_hs),
    .rdata_o (m_axi_wdata),
    .count_o (fifo_count),
    .full_o  (fifo_full)
  );

  // Outputs are gated by rst so no handshake can complete in a reset cycle.
  assign idle_o        = rst || (state_q == StIdle);
  assign res_ready_o   = !rst && (state_q != StIdle) && !fifo_full;
  assign m_axi_awvalid = !rst && (state_q == StAw);
  assign m_axi_wvalid  = !rst && (state_q == StW);
  assign m_axi_wlast   = (state_q == StW) && (beat_idx_q == beats_q - 6'd1);
  assign error_o       = !rst && error_q;
  assign done_o        = !rst && job_end;

  assign m_axi_awid     = '0;
  assign m_axi_awaddr   = cur_addr_q;
  assign m_axi_awlen    = 8'(beats_q - 6'd1);
  assign m_axi_awsize   = AWSIZE_128B;
  assign m_axi_awburst  = BURST_INCR;
  assign m_axi_awuser   = user_q;
  assign m_axi_awcache  = CACHE_NORMAL;
  assign m_axi_awlock   = 2'b00;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_awqos    = 4'h0;
  assign m_axi_awregion = 4'h0;
  assign m_axi_wstrb    = '1;
  assign m_axi_bready   = 1'b1;

  assign push  = res_valid_i && res_ready_o;
  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;
  assign b_ok  = m_axi_bvalid && (out_q != '0);

  // Beats left before the next 4 KB page; cur_addr is always beat aligned.
  assign page_room = 6'd32 - {1'b0, cur_addr_q[11:7]};
  assign can_issue = out_q < OutW'(MAX_OUTSTANDING);
  assign fill_ok   = (fifo_count >= BurstMax) ||
                     ((page_room < BurstMax) && (fifo_count >= page_room)) ||
                     (done_pend_q && (fifo_count != '0));
  assign job_end   = (state_q == StCollect) && done_pend_q && (fifo_count == '0) &&
                     (out_q == '0) && !push;

  always_comb begin
    beats_calc = BurstMax;
    if (fifo_count < beats_calc) beats_calc = fifo_count;
    if (page_room < beats_calc)  beats_calc = page_room;
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    user_d      = user_q;
    done_pend_d = done_pend_q;
    error_d     = error_q;
    beats_d     = beats_q;
    beat_idx_d  = beat_idx_q;
    out_d       = out_q;

    unique case (state_q)
      StIdle: begin
        if (job_start_i) begin
          state_d     = StCollect;
          cur_addr_d  = job_addr_i;
          user_d      = job_user_i;
          done_pend_d = 1'b0;
          error_d     = 1'b0;
        end
      end
      StCollect: begin
        if (job_end) begin
          state_d     = StIdle;
          done_pend_d = 1'b0;
        end else if (can_issue && fill_ok) begin
          state_d = StAw;
          beats_d = beats_calc;
        end
      end
      StAw: begin
        beat_idx_d = '0;
        if (aw_hs) state_d = StW;
      end
      StW: begin
        if (w_hs) begin
          if (m_axi_wlast) begin
            state_d    = StCollect;
            cur_addr_d = cur_addr_q +
                         (ADDR_WIDTH'(beats_q) * ADDR_WIDTH'(BEAT_BYTES));
          end else begin
            beat_idx_d = beat_idx_q + 6'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (job_done_i && (state_q != StIdle)) done_pend_d = 1'b1;

    // A response with nothing outstanding is spurious: flag it, never underflow.
    if (m_axi_bvalid && ((m_axi_bresp != 2'b00) || (m_axi_bid != '0) || (out_q == '0))) begin
      error_d = 1'b1;
    end

    unique case ({aw_hs, b_ok})
      2'b10:   out_d = out_q + OutW'(1);
      2'b01:   out_d = out_q - OutW'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      user_q      <= '0;
      done_pend_q <= 1'b0;
      error_q     <= 1'b0;
      beats_q     <= '0;
      beat_idx_q  <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      user_q      <= user_d;
      done_pend_q <= done_pend_d;
      error_q     <= error_d;
      beats_q     <= beats_d;
      beat_idx_q  <= beat_idx_d;
      out_q       <= out_d;
    end
  end

endmodule

// File: tb/tb_job_writer.sv
// Directed bench for job_writer: burst formation, 4 KB split, outstanding cap,
// error reporting, AW back-pressure and reset during a write burst.
module tb_job_writer;

  localparam int unsigned DW  = 1024;
  localparam int unsigned AW  = 64;
  localparam int unsigned UW  = 9;
  localparam int unsigned IDW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_start_i = 1'b0;
  logic [AW-1:0] job_addr_i = '0;
  logic [UW-1:0] job_user_i = '0;
  logic          job_done_i = 1'b0;
  logic          res_valid_i = 1'b0;
  logic          res_ready_o;
  logic [DW-1:0] res_data_i = '0;
  logic          done_o, error_o, idle_o;
  logic [IDW-1:0] m_axi_awid;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic [UW-1:0] m_axi_awuser;
  logic [3:0]    m_axi_awcache;
  logic [1:0]    m_axi_awlock;
  logic [2:0]    m_axi_awprot;
  logic [3:0]    m_axi_awqos, m_axi_awregion;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b1;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid;
  logic          m_axi_wready = 1'b1;
  logic [IDW-1:0] m_axi_bid = '0;
  logic [1:0]    m_axi_bresp = 2'b00;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;

  job_writer u_dut (
    .clk            (clk),
    .rst            (rst),
    .job_start_i    (job_start_i),
    .job_addr_i     (job_addr_i),
    .job_user_i     (job_user_i),
    .job_done_i     (job_done_i),
    .res_valid_i    (res_valid_i),
    .res_ready_o    (res_ready_o),
    .res_data_i     (res_data_i),
    .done_o         (done_o),
    .error_o        (error_o),
    .idle_o         (idle_o),
    .m_axi_awid     (m_axi_awid),
    .m_axi_awaddr   (m_axi_awaddr),
    .m_axi_awlen    (m_axi_awlen),
    .m_axi_awsize   (m_axi_awsize),
    .m_axi_awburst  (m_axi_awburst),
    .m_axi_awuser   (m_axi_awuser),
    .m_axi_awcache  (m_axi_awcache),
    .m_axi_awlock   (m_axi_awlock),
    .m_axi_awprot   (m_axi_awprot),
    .m_axi_awqos    (m_axi_awqos),
    .m_axi_awregion (m_axi_awregion),
    .m_axi_awvalid  (m_axi_awvalid),
    .m_axi_awready  (m_axi_awready),
    .m_axi_wdata    (m_axi_wdata),
    .m_axi_wstrb    (m_axi_wstrb),
    .m_axi_wlast    (m_axi_wlast),
    .m_axi_wvalid   (m_axi_wvalid),
    .m_axi_wready   (m_axi_wready),
    .m_axi_bid      (m_axi_bid),
    .m_axi_bresp    (m_axi_bresp),
    .m_axi_bvalid   (m_axi_bvalid),
    .m_axi_bready   (m_axi_bready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int b_cyc = 0;

  logic [AW-1:0] aw_addr [$];
  logic [7:0]    aw_len  [$];
  logic [UW-1:0] aw_user [$];
  int            aw_cyc  [$];
  logic [DW-1:0] w_data  [$];
  logic          w_last  [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change 1 ns after a rising edge, so what is seen here is what the next edge samples.
  always @(negedge clk) begin
    if (m_axi_awvalid && m_axi_awready) begin
      aw_addr.push_back(m_axi_awaddr);
      aw_len.push_back(m_axi_awlen);
      aw_user.push_back(m_axi_awuser);
      aw_cyc.push_back(cyc);
    end
    if (m_axi_wvalid && m_axi_wready) begin
      w_data.push_back(m_axi_wdata);
      w_last.push_back(m_axi_wlast);
    end
  end

  function automatic logic [DW-1:0] beat(input int unsigned tag);
    return {32{tag}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    aw_addr.delete(); aw_len.delete(); aw_user.delete(); aw_cyc.delete();
    w_data.delete(); w_last.delete();
  endtask

  task automatic start_job(input logic [AW-1:0] a, input logic [UW-1:0] u);
    job_start_i = 1'b1; job_addr_i = a; job_user_i = u;
    tick();
    job_start_i = 1'b0;
  endtask

  task automatic pulse_done();
    job_done_i = 1'b1;
    tick();
    job_done_i = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] resp);
    m_axi_bvalid = 1'b1; m_axi_bresp = resp; b_cyc = cyc;
    tick();
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
  endtask

  task automatic push_beats(input int n, input int unsigned base, output bit ok);
    bit acc;
    int guard;
    ok = 1'b1;
    for (int k = 0; k < n && ok; k++) begin
      acc = 1'b0; guard = 0;
      res_valid_i = 1'b1; res_data_i = beat(base + k);
      while (!acc && ok) begin
        @(negedge clk);
        acc = res_ready_o;
        tick();
        guard++;
        if (guard > 300) ok = 1'b0;
      end
    end
    res_valid_i = 1'b0;
  endtask

  task automatic wait_aw(input int n, output bit ok);
    for (int g = 0; g < 300 && aw_addr.size() < n; g++) tick();
    ok = (aw_addr.size() >= n);
  endtask

  task automatic wait_w(input int n, output bit ok);
    for (int g = 0; g < 600 && w_data.size() < n; g++) tick();
    ok = (w_data.size() >= n);
  endtask

  task automatic wait_done(output bit ok, output bit err);
    ok = 1'b0; err = 1'b0;
    for (int g = 0; g < 200 && !ok; g++) begin
      @(negedge clk);
      if (done_o) begin ok = 1'b1; err = error_o; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    n_vec++;
    if ({m_axi_awvalid, m_axi_wvalid, done_o, error_o, res_ready_o, idle_o} !== 6'b000001) begin
      n_err++;
      $display("FAIL reset_during: aw,w,done,err,rdy,idle=%b expected 000001",
               {m_axi_awvalid, m_axi_wvalid, done_o, error_o, res_ready_o, idle_o});
    end
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if ({m_axi_awvalid, m_axi_wvalid, done_o, error_o, res_ready_o, idle_o} !== 6'b000001) begin
      n_err++;
      $display("FAIL reset_after: aw,w,done,err,rdy,idle=%b expected 000001",
               {m_axi_awvalid, m_axi_wvalid, done_o, error_o, res_ready_o, idle_o});
    end
  endtask

  task automatic test_single_burst();
    bit ok1, ok2, ok3, err;
    int bad;
    clear_logs();
    start_job(64'h1000, 9'h05);
    n_vec++;
    if ({idle_o, res_ready_o} !== 2'b01) begin
      n_err++;
      $display("FAIL single_started: idle,rdy=%b expected 01", {idle_o, res_ready_o});
    end
    push_beats(8, 0, ok1);
    pulse_done();
    wait_w(8, ok2);
    n_vec++;
    if (!(ok1 && ok2)) begin
      n_err++;
      $display("FAIL single_flow: push_ok=%0d w_ok=%0d expected 1 1", ok1, ok2);
    end
    n_vec++;
    if (aw_addr.size() != 1 || aw_addr[0] !== 64'h1000 || aw_len[0] !== 8'd7 ||
        aw_user[0] !== 9'h05) begin
      n_err++;
      $display("FAIL single_aw: count=%0d addr=%h len=%0d user=%h expected 1 1000 7 005",
               aw_addr.size(), aw_addr[0], aw_len[0], aw_user[0]);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (w_data[i] !== beat(i) || w_last[i] !== (i == 7)) bad++;
    end
    n_vec++;
    if (w_data.size() != 8 || bad != 0) begin
      n_err++;
      $display("FAIL single_wbeats: beats=%0d bad=%0d expected 8 0", w_data.size(), bad);
    end
    n_vec++;
    if (m_axi_awid !== 1'b0 || m_axi_awsize !== 3'd7 || m_axi_awburst !== 2'd1 ||
        m_axi_awcache !== 4'd3 || m_axi_awlock !== 2'd0 || m_axi_awprot !== 3'd0 ||
        m_axi_awqos !== 4'd0 || m_axi_awregion !== 4'd0 || m_axi_wstrb !== {(DW/8){1'b1}} ||
        m_axi_bready !== 1'b1) begin
      n_err++;
      $display("FAIL const_fields: id=%h size=%0d burst=%0d cache=%0d bready=%b expected 0 7 1 3 1",
               m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_bready);
    end
    repeat (3) tick();
    n_vec++;
    if ({done_o, idle_o} !== 2'b00) begin
      n_err++;
      $display("FAIL single_wait_b: done,idle=%b expected 00", {done_o, idle_o});
    end
    send_b(2'b00);
    wait_done(ok3, err);
    n_vec++;
    if (!ok3 || err || idle_o !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: done_seen=%0d err=%0d idle=%b expected 1 0 1", ok3, err, idle_o);
    end
  endtask

  task automatic test_page_split();
    bit ok1, ok2, ok3, err;
    clear_logs();
    start_job(64'h1F00, 9'h11);
    push_beats(4, 16, ok1);
    pulse_done();
    wait_aw(2, ok2);
    wait_w(4, ok2);
    n_vec++;
    if (aw_addr.size() != 2 || aw_addr[0] !== 64'h1F00 || aw_len[0] !== 8'd1 ||
        aw_addr[1] !== 64'h2000 || aw_len[1] !== 8'd1) begin
      n_err++;
      $display("FAIL page_split: n=%0d a0=%h l0=%0d a1=%h l1=%0d expected 2 1f00 1 2000 1",
               aw_addr.size(), aw_addr[0], aw_len[0], aw_addr[1], aw_len[1]);
    end
    n_vec++;
    if (w_last[1] !== 1'b1 || w_last[3] !== 1'b1 || w_last[0] !== 1'b0 ||
        w_data[2] !== beat(18)) begin
      n_err++;
      $display("FAIL page_split_w: last=%b%b%b%b expected 0101 or beat2 data wrong",
               w_last[0], w_last[1], w_last[2], w_last[3]);
    end
    send_b(2'b00);
    send_b(2'b00);
    wait_done(ok3, err);
    n_vec++;
    if (!(ok1 && ok3) || err) begin
      n_err++;
      $display("FAIL page_split_done: push=%0d done=%0d err=%0d expected 1 1 0", ok1, ok3, err);
    end
  endtask

  task automatic test_outstanding();
    bit ok1, ok2, ok3, err;
    int bad;
    clear_logs();
    start_job(64'h0, 9'h22);
    push_beats(40, 100, ok1);
    pulse_done();
    repeat (20) tick();
    n_vec++;
    if (aw_addr.size() != 4 || aw_addr[3] !== 64'hC00) begin
      n_err++;
      $display("FAIL outstanding_cap: aws=%0d last_addr=%h expected 4 c00",
               aw_addr.size(), aw_addr[3]);
    end
    send_b(2'b00);
    wait_aw(5, ok2);
    n_vec++;
    if (!ok2 || aw_cyc[4] <= b_cyc || aw_addr[4] !== 64'h1000) begin
      n_err++;
      $display("FAIL outstanding_5th: seen=%0d aw_cyc=%0d b_cyc=%0d addr=%h expected after, 1000",
               ok2, aw_cyc[4], b_cyc, aw_addr[4]);
    end
    wait_w(40, ok2);
    bad = 0;
    for (int i = 0; i < 40; i++) if (w_data[i] !== beat(100 + i)) bad++;
    n_vec++;
    if (!ok2 || bad != 0) begin
      n_err++;
      $display("FAIL outstanding_data: w_ok=%0d bad=%0d expected 1 0", ok2, bad);
    end
    repeat (4) send_b(2'b00);
    wait_done(ok3, err);
    n_vec++;
    if (!(ok1 && ok3) || err) begin
      n_err++;
      $display("FAIL outstanding_done: push=%0d done=%0d err=%0d expected 1 1 0", ok1, ok3, err);
    end
  endtask

  task automatic test_error();
    bit ok1, ok2, ok3, err;
    clear_logs();
    start_job(64'h4000, 9'h33);
    push_beats(16, 200, ok1);
    pulse_done();
    wait_w(16, ok2);
    send_b(2'b00);
    n_vec++;
    if (error_o !== 1'b0) begin
      n_err++;
      $display("FAIL error_okay_b: error_o=%b expected 0", error_o);
    end
    send_b(2'b10);
    n_vec++;
    if (error_o !== 1'b1) begin
      n_err++;
      $display("FAIL error_set: error_o=%b expected 1", error_o);
    end
    wait_done(ok3, err);
    n_vec++;
    if (!(ok1 && ok2 && ok3) || !err || error_o !== 1'b1) begin
      n_err++;
      $display("FAIL error_sticky: done=%0d err_at_done=%0d err_now=%b expected 1 1 1",
               ok3, err, error_o);
    end
    start_job(64'h6000, 9'h34);
    n_vec++;
    if (error_o !== 1'b0) begin
      n_err++;
      $display("FAIL error_clear: error_o=%b expected 0", error_o);
    end
    pulse_done();
    wait_done(ok3, err);
    n_vec++;
    if (!ok3 || err || aw_addr.size() != 2) begin
      n_err++;
      $display("FAIL empty_job: done=%0d err=%0d aws=%0d expected 1 0 2", ok3, err, aw_addr.size());
    end
  endtask

  task automatic test_aw_stall();
    bit ok1, ok2, ok3, err, seen;
    clear_logs();
    m_axi_awready = 1'b0;
    start_job(64'h3000, 9'h44);
    push_beats(8, 300, ok1);
    pulse_done();
    seen = 1'b0;
    for (int g = 0; g < 100 && !seen; g++) begin
      @(negedge clk);
      seen = m_axi_awvalid;
      tick();
    end
    n_vec++;
    if (!(ok1 && seen)) begin
      n_err++;
      $display("FAIL stall_awvalid: push=%0d awvalid_seen=%0d expected 1 1", ok1, seen);
    end
    for (int i = 0; i < 10; i++) begin
      job_start_i = (i == 4);
      job_addr_i  = 64'h5000;
      @(negedge clk);
      n_vec++;
      if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 64'h3000 || m_axi_awlen !== 8'd7 ||
          m_axi_wvalid !== 1'b0) begin
        n_err++;
        $display("FAIL stall_cycle%0d: awv=%b addr=%h len=%0d wv=%b expected 1 3000 7 0",
                 i, m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_wvalid);
      end
      tick();
    end
    job_start_i   = 1'b0;
    m_axi_awready = 1'b1;
    wait_w(8, ok2);
    send_b(2'b00);
    wait_done(ok3, err);
    n_vec++;
    if (!(ok2 && ok3) || err || aw_addr.size() != 1 || aw_addr[0] !== 64'h3000) begin
      n_err++;
      $display("FAIL stall_done: w=%0d done=%0d aws=%0d addr=%h expected 1 1 1 3000",
               ok2, ok3, aw_addr.size(), aw_addr[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2, ok3, err, seen;
    int bad;
    clear_logs();
    m_axi_wready = 1'b0;
    start_job(64'h0, 9'h55);
    push_beats(8, 400, ok1);
    seen = 1'b0;
    for (int g = 0; g < 100 && !seen; g++) begin
      @(negedge clk);
      seen = m_axi_wvalid;
      tick();
    end
    rst = 1'b1;
    m_axi_wready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (!seen || m_axi_wvalid !== 1'b0 || m_axi_awvalid !== 1'b0 || w_data.size() != 0) begin
      n_err++;
      $display("FAIL rst_mid_cycle: wv_seen=%0d wv=%b awv=%b wbeats=%0d expected 1 0 0 0",
               seen, m_axi_wvalid, m_axi_awvalid, w_data.size());
    end
    tick();
    rst = 1'b0;
    n_vec++;
    if ({idle_o, m_axi_awvalid, m_axi_wvalid, res_ready_o} !== 4'b1000) begin
      n_err++;
      $display("FAIL rst_mid_after: idle,awv,wv,rdy=%b expected 1000",
               {idle_o, m_axi_awvalid, m_axi_wvalid, res_ready_o});
    end
    clear_logs();
    start_job(64'h8000, 9'h66);
    push_beats(8, 500, ok2);
    pulse_done();
    wait_w(8, ok3);
    bad = 0;
    for (int i = 0; i < 8; i++) if (w_data[i] !== beat(500 + i)) bad++;
    n_vec++;
    if (!(ok1 && ok2 && ok3) || bad != 0 || aw_addr.size() != 1 || aw_addr[0] !== 64'h8000 ||
        aw_len[0] !== 8'd7) begin
      n_err++;
      $display("FAIL rst_new_job: bad=%0d aws=%0d addr=%h len=%0d expected 0 1 8000 7",
               bad, aw_addr.size(), aw_addr[0], aw_len[0]);
    end
    send_b(2'b00);
    wait_done(ok3, err);
    n_vec++;
    if (!ok3 || err) begin
      n_err++;
      $display("FAIL rst_new_done: done=%0d err=%0d expected 1 0", ok3, err);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_page_split();
    test_outstanding();
    test_error();
    test_aw_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
